// File: rtl/systolic_drain_ctrl_if.sv
// Signal bundle between the drain controller, the systolic array and the result sink.
// The master modport is the controller side; slave is the array/sink side.
interface systolic_drain_ctrl_if #(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                    start_i;
  logic                    start_matrix_mult_o;
  logic                    matrix_mult_complete_i;
  logic [N*N-1:0]          select_accumulator_o;
  logic [N*N-1:0]          accumulator_valid_i;
  logic [N*DATA_WIDTH-1:0] row_data_i;
  logic                    res_valid_o;
  logic                    res_ready_i;
  logic [DATA_WIDTH-1:0]   res_data_o;
  logic [$clog2(N)-1:0]    res_row_o;
  logic [$clog2(N)-1:0]    res_col_o;
  logic                    res_last_o;
  logic                    busy_o;
  logic                    done_o;
  logic                    timeout_o;

  modport master (
    input  start_i, matrix_mult_complete_i, accumulator_valid_i, row_data_i, res_ready_i,
    output start_matrix_mult_o, select_accumulator_o, res_valid_o, res_data_o, res_row_o,
           res_col_o, res_last_o, busy_o, done_o, timeout_o
  );

  modport slave (
    output start_i, matrix_mult_complete_i, accumulator_valid_i, row_data_i, res_ready_i,
    input  start_matrix_mult_o, select_accumulator_o, res_valid_o, res_data_o, res_row_o,
           res_col_o, res_last_o, busy_o, done_o, timeout_o
  );

endinterface

// File: rtl/systolic_drain_ctrl.sv
// Starts one systolic multiply, waits for it to settle, then drains every PE accumulator
// in row-major order as a valid/ready stream, substituting zero for PEs that never respond.
module systolic_drain_ctrl #(
  parameter int unsigned N             = 8,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned SETTLE_CYCLES = 20,
  parameter int unsigned VALID_TIMEOUT = 64
) (
  input logic                   clk_i,
  input logic                   rstn_i,
  systolic_drain_ctrl_if.master bus
);

  localparam int unsigned NumPe = N * N;
  localparam int unsigned IdxW  = $clog2(NumPe);
  localparam int unsigned RcW   = $clog2(N);
  localparam int unsigned CntW  = 10;

  typedef enum logic [2:0] {
    StIdle, StStart, StCompute, StSettle, StSelect, StOutput, StDone
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [RcW-1:0]        row_q, row_d, col_q, col_d;
  logic                  timeout_q, timeout_d;

  logic [RcW-1:0]        cur_row, cur_col;
  logic [DATA_WIDTH-1:0] row_sel_data;
  logic [NumPe-1:0]      sel_one_hot;
  logic                  last_idx, pe_valid;

  assign cur_row  = RcW'(idx_q / IdxW'(N));
  assign cur_col  = RcW'(idx_q % IdxW'(N));
  assign last_idx = (idx_q == IdxW'(NumPe - 1));
  assign pe_valid = bus.accumulator_valid_i[idx_q];
  // One shared counter serves SETTLE and the SELECT timeout; it saturates instead of wrapping.
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    row_sel_data = '0;
    for (int r = 0; r < int'(N); r++) begin
      if (cur_row == RcW'(r)) row_sel_data = bus.row_data_i[r*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    sel_one_hot        = '0;
    sel_one_hot[idx_q] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    idx_d     = idx_q;
    data_d    = data_q;
    row_d     = row_q;
    col_d     = col_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle:    if (bus.start_i) state_d = StStart;
      StStart: begin
        state_d   = StCompute;
        idx_d     = '0;
        timeout_d = 1'b0;
      end
      StCompute: if (bus.matrix_mult_complete_i) state_d = StSettle;
      StSettle:  if (cnt_q >= CntW'(SETTLE_CYCLES - 1)) state_d = StSelect;
      StSelect: begin
        if (pe_valid) begin
          data_d  = row_sel_data;
          row_d   = cur_row;
          col_d   = cur_col;
          state_d = StOutput;
        end else if (cnt_q >= CntW'(VALID_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          data_d    = '0;
          row_d     = cur_row;
          col_d     = cur_col;
          state_d   = StOutput;
        end
      end
      StOutput: begin
        if (bus.res_ready_i) begin
          if (last_idx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StSelect;
          end
        end
      end
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      row_q     <= row_d;
      col_q     <= col_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.start_matrix_mult_o  = (state_q == StStart);
  assign bus.select_accumulator_o = (state_q == StSelect) ? sel_one_hot : '0;
  assign bus.res_valid_o          = (state_q == StOutput);
  assign bus.res_data_o           = data_q;
  assign bus.res_row_o            = row_q;
  assign bus.res_col_o            = col_q;
  assign bus.res_last_o           = (state_q == StOutput) && last_idx;
  assign bus.busy_o               = (state_q != StIdle);
  assign bus.done_o               = (state_q == StDone);
  assign bus.timeout_o            = timeout_q;

endmodule

// File: doc/systolic_drain_ctrl.md
SYSTOLIC_DRAIN_CTRL -- requirements
Module: systolic_drain_ctrl

Interface
REQ-001 Parameter N, default 8: array dimension, N x N PEs.
REQ-002 Parameter DATA_WIDTH, default 32: accumulator width.
REQ-003 Parameter SETTLE_CYCLES, default 20: wait cycles between completion and first readout, range 1-255.
REQ-004 Parameter VALID_TIMEOUT, default 64: maximum wait cycles for an accumulator valid, range 2-1023.
REQ-005 Port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port rstn_i, input, 1: reset, asynchronous and active-low.
REQ-007 Port start_i, input, 1: request one multiply-and-drain run.
REQ-008 Port start_matrix_mult_o, output, 1: start pulse to the array.
REQ-009 Port matrix_mult_complete_i, input, 1: array completion flag.
REQ-010 Port select_accumulator_o, output, N*N: one-hot PE select; bit r*N+c selects PE[r][c].
REQ-011 Port accumulator_valid_i, input, N*N: per-PE valid, same indexing.
REQ-012 Port row_data_i, input, N*DATA_WIDTH: slice r carries the selected PE value of row r.
REQ-013 Port res_valid_o, output, 1: result beat valid.
REQ-014 Port res_ready_i, input, 1: downstream accepts the beat.
REQ-015 Port res_data_o, output, DATA_WIDTH: captured C[r][c].
REQ-016 Ports res_row_o and res_col_o, output, $clog2(N) each: coordinates of the beat.
REQ-017 Port res_last_o, output, 1: beat is C[N-1][N-1].
REQ-018 Port busy_o, output, 1: block is not in IDLE.
REQ-019 Port done_o, output, 1: one-cycle pulse at the end of a run.
REQ-020 Port timeout_o, output, 1: sticky flag, set when any PE valid times out.

Function
REQ-021 FSM states SHALL be IDLE, START, COMPUTE, SETTLE, SELECT, OUTPUT and DONE; busy_o SHALL be 1 in every state except IDLE.
REQ-022 IDLE SHALL go to START when start_i=1; start_i SHALL be ignored in every other state.
REQ-023 START SHALL last exactly 1 cycle, with start_matrix_mult_o=1 only in this state; it SHALL go to COMPUTE and clear the PE index and timeout_o.
REQ-024 COMPUTE SHALL go to SETTLE on the first cycle that samples matrix_mult_complete_i=1; there is no timeout in COMPUTE.
REQ-025 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to SELECT.
REQ-026 SELECT SHALL drive select_accumulator_o as one-hot at the current index (row-major, index = r*N+c); all select bits SHALL be 0 in all other states.
REQ-027 In SELECT, a sampled accumulator_valid_i[index]=1 SHALL capture row_data_i slice r into res_data_o, load res_row_o and res_col_o, and go to OUTPUT on the next cycle.
REQ-028 If the valid has not arrived after VALID_TIMEOUT SELECT cycles, the block SHALL set timeout_o, capture res_data_o=0 and go to OUTPUT.
REQ-029 Valid bits of non-selected PEs SHALL be ignored.
REQ-030 OUTPUT SHALL hold res_valid_o=1 with res_data_o, res_row_o, res_col_o and res_last_o stable until res_valid_o and res_ready_i are both 1.
REQ-031 On a transfer in OUTPUT, the block SHALL go to DONE if the index is N*N-1; otherwise it SHALL increment the index and return to SELECT.
REQ-032 res_ready_i=1 outside OUTPUT SHALL have no effect.
REQ-033 DONE SHALL last exactly 1 cycle with done_o=1, then go to IDLE.
REQ-034 res_last_o SHALL be 1 only while res_valid_o=1 and the index is N*N-1.
REQ-035 Exactly N*N beats SHALL be emitted per run, each exactly once, in row-major order.
REQ-036 The SETTLE counter and the timeout counter SHALL saturate, never wrap, and SHALL be cleared on every state entry.

Reset
REQ-037 rstn_i=0 SHALL immediately force IDLE, a zero index and zero counters.
REQ-038 rstn_i=0 SHALL immediately drive start_matrix_mult_o, select_accumulator_o, res_valid_o, res_data_o, res_row_o, res_col_o, res_last_o, busy_o, done_o and timeout_o to 0.
REQ-039 Reset asserted mid-run, in any state, SHALL abandon the run; no beat or done_o SHALL follow until a new start_i.

Verification
REQ-040 N=2, SETTLE_CYCLES=3, res_ready_i held at 1, valid returned 2 cycles after each select -> one start pulse; exactly 4 beats in order (0,0),(0,1),(1,0),(1,1); res_last_o only on (1,1); done_o 1 cycle after the last beat.
REQ-041 Complete rises 5 cycles after start -> first select bit rises exactly SETTLE_CYCLES+1 cycles after complete is sampled.
REQ-042 PE[0][1] valid never arrives, VALID_TIMEOUT=8 -> beat (0,1) carries data 0 after 8 SELECT cycles; timeout_o=1; the run still finishes; timeout_o clears on the next START.
REQ-043 res_ready_i held at 0 for 10 cycles during beat (1,0) with data 0x0000_1234 -> payload stable for all 10 cycles; no select is active; the next select begins only after the transfer.
REQ-044 start_i pulsed while busy_o=1, and rstn_i=0 asserted in SELECT -> no second start pulse for the busy-time request; after reset all outputs are 0 and the block is IDLE; a new start_i runs a full N*N drain.
